addition_unit: RTL and testbench
================================

Name: addition_unit

Overview:
- Registered two's-complement adder with status flags.
- Adds two WIDTH-bit operands and produces the sum plus zero, overflow, carry and negative flags, all registered on one clock edge.
- Serves as the arithmetic core for program-counter increment (PC+1) and branch-target computation (PC+1+offset) in the pipeline CPU, and is reusable by the ALU.

Parameters:
- WIDTH, 32, operand/result width in bits. Must be a multiple of 4 and at least 4.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- a  input  WIDTH  operand A (unsigned or two's-complement)
- b  input  WIDTH  operand B (unsigned or two's-complement)
- result  output  WIDTH  registered sum a+b, modulo 2^WIDTH
- zero  output  1  registered; 1 when result is all zeros
- overflow  output  1  registered; signed overflow of a+b
- carry  output  1  registered; unsigned carry-out of bit WIDTH-1
- negative  output  1  registered; copy of result MSB

Behaviour:
- Synchronous operation: at each rising clk edge with reset=0, the outputs capture values computed from the a and b present before that edge. Latency is exactly 1 cycle.
- No enable and no handshake: a new operation is accepted every cycle, giving a throughput of 1 per cycle.
- Reset: at a rising edge with reset=1, result=0, zero=0, overflow=0, carry=0, negative=0. Reset overrides any inputs.
- Reset mid-stream: the first edge with reset=1 clears outputs regardless of a and b. The first edge after reset deasserts captures the current a+b normally. No pipeline residue remains.
- Arithmetic:
  - sum = (a + b) mod 2^WIDTH; carry-in is fixed at 0.
  - carry = bit WIDTH of the full (WIDTH+1)-bit sum.
  - overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]); equivalently, carry-into-MSB XOR carry-out-of-MSB.
  - negative = sum[MSB].
  - zero = (sum == 0). All four flags are derived from the same-cycle sum and registered together with result.
- Structure:
  - Combinational datapath built from 4-bit carry-lookahead groups, each with per-bit generate/propagate, group carries and a group carry-out.
  - Groups are rippled from LSB group to MSB group.
  - Carry into the MSB is exposed internally for the overflow computation.
  - Zero detect is a reduction NOR over sum.
  - Output registers sit after the flag logic.
- Boundary conditions:
  - a=b=0: result=0, zero=1, all other flags 0.
  - All-ones plus 1: wraps to 0, zero=1, carry=1, overflow=0.
  - Most-positive plus 1: overflow=1, negative=1, carry=0.
  - Most-negative plus most-negative: result=0, zero=1, carry=1, overflow=1.
  - Inputs changing between edges have no effect on outputs until the next edge.
- No X propagation from reset: outputs are defined from the first reset edge onward.

Test Plan:
- Reset held 2 cycles with a=0x12345678, b=0x1 -> all outputs 0. Release reset -> next edge result=0x12345679, all flags 0.
- PC increment: a=0x00000005, b=0x00000001 -> one cycle later result=0x00000006, zero=0, carry=0, overflow=0, negative=0.
- Branch offset: a=0x00000006, b=0x00000019 -> result=0x0000001F with all flags 0. Next cycle a=0x0000000B, b=0xFFFFFFFD -> result=0x00000008, carry=1, overflow=0, negative=0.
- Wrap and overflow:
  - 0xFFFFFFFF+0x00000001 -> result=0, zero=1, carry=1, overflow=0.
  - 0x7FFFFFFF+0x00000001 -> result=0x80000000, overflow=1, negative=1, carry=0.
  - 0x80000000+0x80000000 -> result=0, zero=1, carry=1, overflow=1, negative=0.
- Back-to-back and latency: apply a new operand pair every cycle for 8 cycles -> each output equals the previous cycle's sum and flags, with no bubbles. Assert reset on cycle 4 -> that cycle's outputs are 0, and correct sums resume the cycle after release.

Source files
------------

// File: rtl/addition_unit_if.sv
// addition_unit_if: operand/result bundle for the registered adder.
// The master drives operands; the slave returns the sum and flags.
interface addition_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             carry;
    logic             negative;

    modport master (
        output a,
        output b,
        input  result,
        input  zero,
        input  overflow,
        input  carry,
        input  negative
    );

    modport slave (
        input  a,
        input  b,
        output result,
        output zero,
        output overflow,
        output carry,
        output negative
    );
endinterface

// File: rtl/addition_unit.sv
// addition_unit: registered two's-complement adder with status flags.
// Datapath is rippled 4-bit carry-lookahead groups; outputs one cycle later.
module addition_unit #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    addition_unit_if.slave  bus
);

    localparam int NG = WIDTH / 4;

    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   c;
    logic             carry_msb;
    logic             carry_out;
    logic             ovf;
    logic             zero_det;

    assign gen  = bus.a & bus.b;
    assign prop = bus.a ^ bus.b;
    assign c[0] = 1'b0;

    for (genvar k = 0; k < NG; k++) begin : g_cla
        localparam int B = 4 * k;

        logic [3:0] gg;
        logic [3:0] pp;
        logic       cin;
        logic       grp_g;
        logic       grp_p;

        assign gg  = gen[B+3:B];
        assign pp  = prop[B+3:B];
        assign cin = c[B];

        assign c[B+1] = gg[0]
                      | (pp[0] & cin);
        assign c[B+2] = gg[1]
                      | (pp[1] & gg[0])
                      | (pp[1] & pp[0] & cin);
        assign c[B+3] = gg[2]
                      | (pp[2] & gg[1])
                      | (pp[2] & pp[1] & gg[0])
                      | (pp[2] & pp[1] & pp[0] & cin);

        // Group generate/propagate let the carry-out skip the bit chain.
        assign grp_g = gg[3]
                     | (pp[3] & gg[2])
                     | (pp[3] & pp[2] & gg[1])
                     | (pp[3] & pp[2] & pp[1] & gg[0]);
        assign grp_p = &pp;

        assign c[B+4] = grp_g | (grp_p & cin);

        assign sum[B+3:B] = pp ^ c[B+3:B];
    end

    // Carry into the MSB versus out of it gives signed overflow.
    assign carry_msb = c[WIDTH-1];
    assign carry_out = c[WIDTH];
    assign ovf       = carry_msb ^ carry_out;
    assign zero_det  = ~|sum;

    // Register sum and all flags together; reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.result   <= '0;
            bus.zero     <= 1'b0;
            bus.overflow <= 1'b0;
            bus.carry    <= 1'b0;
            bus.negative <= 1'b0;
        end else begin
            bus.result   <= sum;
            bus.zero     <= zero_det;
            bus.overflow <= ovf;
            bus.carry    <= carry_out;
            bus.negative <= sum[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_addition_unit.sv
// tb_addition_unit: directed scoreboard bench for addition_unit.
// Expected sums/flags are queued at drive time and checked after the edge.
module tb_addition_unit;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] result;
        logic         zero;
        logic         overflow;
        logic         carry;
        logic         negative;
    } exp_t;

    logic clk;
    logic reset;

    int total;
    int passed;

    exp_t sb[$];
    exp_t last;

    addition_unit_if #(.WIDTH(W)) bus ();

    addition_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic r,
                                   input logic [W-1:0] x,
                                   input logic [W-1:0] y);
        exp_t e;
        logic [W:0] full;
        e = '0;
        if (!r) begin
            full       = {1'b0, x} + {1'b0, y};
            e.result   = full[W-1:0];
            e.carry    = full[W];
            e.zero     = (full[W-1:0] == '0);
            e.negative = full[W-1];
            e.overflow = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
        end
        return e;
    endfunction

    task automatic chk(input string tag,
                       input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic compare(input string tag, input exp_t e);
        chk({tag, ".result"}, bus.result, e.result);
        chk({tag, ".zero"}, W'(bus.zero), W'(e.zero));
        chk({tag, ".overflow"}, W'(bus.overflow), W'(e.overflow));
        chk({tag, ".carry"}, W'(bus.carry), W'(e.carry));
        chk({tag, ".negative"}, W'(bus.negative), W'(e.negative));
    endtask

    task automatic step(input string tag,
                        input logic r,
                        input logic [W-1:0] x,
                        input logic [W-1:0] y);
        exp_t e;
        @(negedge clk);
        reset = r;
        bus.a = x;
        bus.b = y;
        sb.push_back(model(r, x, y));
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e    = sb.pop_front();
            last = e;
            compare(tag, e);
        end
    endtask

    initial begin
        total  = 0;
        passed = 0;
        reset  = 1'b1;
        bus.a  = '0;
        bus.b  = '0;

        step("rst0", 1'b1, 32'h1234_5678, 32'h0000_0001);
        step("rst1", 1'b1, 32'h1234_5678, 32'h0000_0001);
        step("rel", 1'b0, 32'h1234_5678, 32'h0000_0001);

        step("pc_inc", 1'b0, 32'h0000_0005, 32'h0000_0001);
        step("br_fwd", 1'b0, 32'h0000_0006, 32'h0000_0019);
        step("br_back", 1'b0, 32'h0000_000B, 32'hFFFF_FFFD);

        step("zero", 1'b0, 32'h0000_0000, 32'h0000_0000);
        step("wrap", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
        step("pos_ovf", 1'b0, 32'h7FFF_FFFF, 32'h0000_0001);
        step("neg_ovf", 1'b0, 32'h8000_0000, 32'h8000_0000);
        step("neg_ok", 1'b0, 32'hFFFF_FFF0, 32'h0000_0008);
        step("mix", 1'b0, 32'h0F0F_0F0F, 32'hF0F0_F0F1);

        // Inputs wiggle mid-cycle: outputs must hold the last capture.
        #2;
        bus.a = 32'hDEAD_BEEF;
        bus.b = 32'h1357_9BDF;
        #1;
        compare("hold", last);

        // Back-to-back stream with a reset pulse on the fourth cycle.
        for (int i = 0; i < 8; i++) begin
            step($sformatf("b2b%0d", i), (i == 3),
                 $urandom(), $urandom());
        end

        step("carry_chain", 1'b0, 32'h0FFF_FFFF, 32'h0000_0001);
        step("mid_group", 1'b0, 32'h0000_FFFF, 32'h0000_FFFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
